// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response port: master issues req/addr/wdata, slave answers addr_ok/data_ok.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, strb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, strb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like master port between instruction fetch and data access; one transaction
// in flight, data wins by default with bounded anti-starvation for instruction fetch.
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                resetn,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master m
);

  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic [StreakW-1:0]   streak_q, streak_d;

  logic sel, cur, owner_req, starved;
  logic req_c, grant;
  logic inst_aok, data_aok, inst_dok, data_dok;

  assign starved   = inst.req && (streak_q == StreakW'(STARVE_LIMIT));
  assign sel       = data.req && !starved;
  assign cur       = (state_q == StIdle) ? sel : owner_q;
  assign owner_req = owner_q ? data.req : inst.req;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    req_c    = 1'b0;
    grant    = 1'b0;
    inst_aok = 1'b0;
    data_aok = 1'b0;
    inst_dok = 1'b0;
    data_dok = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_c = inst.req || data.req;
        if (req_c) begin
          owner_d = sel;
          if (m.addr_ok) grant = 1'b1;
          else           state_d = StAddr;
        end
      end
      StAddr: begin
        // Owner withdrawing its request is a protocol violation; abandon without issuing.
        if (owner_req) begin
          req_c = 1'b1;
          if (m.addr_ok) grant = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (m.data_ok) begin
          inst_dok = !owner_q;
          data_dok = owner_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      inst_aok = !cur;
      data_aok = cur;
      state_d  = StData;
      if (cur && inst.req) begin
        if (streak_q != StreakW'(STARVE_LIMIT)) streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Every output is forced low while reset is asserted.
  assign m.req   = resetn && req_c;
  assign m.wr    = resetn && cur && data.wr;
  assign m.strb  = (resetn && cur) ? data.strb : 4'h0;
  assign m.addr  = !resetn ? 32'h0 : (cur ? data.addr : inst.addr);
  assign m.wdata = (resetn && cur) ? data.wdata : 32'h0;

  assign inst.addr_ok = resetn && inst_aok;
  assign data.addr_ok = resetn && data_aok;
  assign inst.data_ok = resetn && inst_dok;
  assign data.data_ok = resetn && data_dok;
  assign inst.rdata   = resetn ? m.rdata : 32'h0;
  assign data.rdata   = resetn ? m.rdata : 32'h0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: table of single-cycle IDLE decisions plus hand sequences for multi-cycle cases.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if inst_bus ();
  sram_like_arbiter_if data_bus ();
  sram_like_arbiter_if mem_bus ();

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_bus),
    .data   (data_bus),
    .m      (mem_bus)
  );

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwr;
    logic [3:0]  strb;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic        maok;
    logic        e_mreq;
    logic        e_mwr;
    logic [3:0]  e_strb;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic        e_iaok;
    logic        e_daok;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.strb = 0; inst_bus.addr = 0; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.strb = 0; data_bus.addr = 0; data_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
  endtask

  // Returns at a falling edge with reset released and the arbiter idle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  vec_t vecs [5];
  logic exp_d [6];

  initial begin
    vecs[0] = '{1, 0, 1, 4'hF, 32'hBFC0_0010, 32'h8000_0000, 32'hAAAA_5555, 1,
                1, 0, 4'h0, 32'hBFC0_0010, 32'h0, 1, 0};
    vecs[1] = '{1, 1, 1, 4'hF, 32'hBFC0_0020, 32'h8000_1004, 32'h1234_5678, 1,
                1, 1, 4'hF, 32'h8000_1004, 32'h1234_5678, 0, 1};
    vecs[2] = '{0, 1, 0, 4'h3, 32'hBFC0_0030, 32'h8000_2000, 32'h0, 0,
                1, 0, 4'h3, 32'h8000_2000, 32'h0, 0, 0};
    vecs[3] = '{0, 0, 1, 4'hC, 32'h0, 32'h8000_3000, 32'h5A5A_A5A5, 1,
                0, 0, 4'h0, 32'h0, 32'h0, 0, 0};
    vecs[4] = '{1, 0, 0, 4'h0, 32'hBFC0_0040, 32'h0, 32'h0, 0,
                1, 0, 4'h0, 32'hBFC0_0040, 32'h0, 0, 0};
    exp_d = '{1, 1, 1, 1, 0, 1};

    // Reset state: everything low even with all inputs active.
    clear_inputs();
    inst_bus.req = 1; data_bus.req = 1; data_bus.wr = 1; data_bus.addr = 32'h8000_0000;
    mem_bus.addr_ok = 1; mem_bus.data_ok = 1; mem_bus.rdata = 32'hFFFF_FFFF;
    #4;
    chk("rst_mreq", 32'(mem_bus.req), 0);
    chk("rst_maddr", mem_bus.addr, 0);
    chk("rst_daok", 32'(data_bus.addr_ok), 0);
    chk("rst_ddok", 32'(data_bus.data_ok), 0);
    chk("rst_idok", 32'(inst_bus.data_ok), 0);
    chk("rst_drdata", data_bus.rdata, 0);

    // Table: IDLE-cycle decisions from a fresh reset.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      inst_bus.req = vecs[i].ireq; inst_bus.addr = vecs[i].iaddr;
      data_bus.req = vecs[i].dreq; data_bus.wr = vecs[i].dwr; data_bus.strb = vecs[i].strb;
      data_bus.addr = vecs[i].daddr; data_bus.wdata = vecs[i].wdata;
      mem_bus.addr_ok = vecs[i].maok;
      #4;
      chk($sformatf("v%0d_mreq", i), 32'(mem_bus.req), 32'(vecs[i].e_mreq));
      chk($sformatf("v%0d_mwr", i), 32'(mem_bus.wr), 32'(vecs[i].e_mwr));
      chk($sformatf("v%0d_mstrb", i), 32'(mem_bus.strb), 32'(vecs[i].e_strb));
      chk($sformatf("v%0d_maddr", i), mem_bus.addr, vecs[i].e_maddr);
      chk($sformatf("v%0d_mwdata", i), mem_bus.wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_iaok", i), 32'(inst_bus.addr_ok), 32'(vecs[i].e_iaok));
      chk($sformatf("v%0d_daok", i), 32'(data_bus.addr_ok), 32'(vecs[i].e_daok));
    end

    // 1: single fetch, data 2 cycles after acceptance.
    do_reset();
    inst_bus.req = 1; inst_bus.addr = 32'hBFC0_0000; mem_bus.addr_ok = 1;
    #4;
    chk("t1_iaok", 32'(inst_bus.addr_ok), 1);
    chk("t1_maddr", mem_bus.addr, 32'hBFC0_0000);
    chk("t1_daok", 32'(data_bus.addr_ok), 0);
    @(negedge clk);
    inst_bus.req = 0; mem_bus.addr_ok = 0;
    #4;
    chk("t1_mreq_data", 32'(mem_bus.req), 0);
    chk("t1_idok_early", 32'(inst_bus.data_ok), 0);
    @(negedge clk);
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h3C08_0001;
    #4;
    chk("t1_idok", 32'(inst_bus.data_ok), 1);
    chk("t1_irdata", inst_bus.rdata, 32'h3C08_0001);
    chk("t1_ddok", 32'(data_bus.data_ok), 0);
    @(negedge clk);
    mem_bus.data_ok = 0;
    #4;
    chk("t1_idok_once", 32'(inst_bus.data_ok), 0);

    // 2: simultaneous requests, store goes first.
    do_reset();
    inst_bus.req = 1; inst_bus.addr = 32'hBFC0_0100;
    data_bus.req = 1; data_bus.wr = 1; data_bus.strb = 4'hF;
    data_bus.addr = 32'h8000_1004; data_bus.wdata = 32'h1234_5678; mem_bus.addr_ok = 1;
    #4;
    chk("t2_mwr", 32'(mem_bus.wr), 1);
    chk("t2_maddr", mem_bus.addr, 32'h8000_1004);
    chk("t2_daok", 32'(data_bus.addr_ok), 1);
    chk("t2_iaok", 32'(inst_bus.addr_ok), 0);
    @(negedge clk);
    data_bus.req = 0;
    #4;
    chk("t2_iaok_data", 32'(inst_bus.addr_ok), 0);
    chk("t2_mreq_data", 32'(mem_bus.req), 0);
    @(negedge clk);
    mem_bus.data_ok = 1;
    #4;
    chk("t2_ddok", 32'(data_bus.data_ok), 1);
    chk("t2_iaok_dok", 32'(inst_bus.addr_ok), 0);
    @(negedge clk);
    mem_bus.data_ok = 0;
    #4;
    chk("t2_iaok_after", 32'(inst_bus.addr_ok), 1);
    chk("t2_maddr_after", mem_bus.addr, 32'hBFC0_0100);

    // 3: anti-starvation, grants D,D,D,D,I,D.
    do_reset();
    inst_bus.req = 1; inst_bus.addr = 32'hBFC0_0200;
    data_bus.req = 1; data_bus.addr = 32'h8000_4000; mem_bus.addr_ok = 1;
    for (int k = 0; k < 6; k++) begin
      #4;
      chk($sformatf("t3_daok%0d", k), 32'(data_bus.addr_ok), 32'(exp_d[k]));
      chk($sformatf("t3_iaok%0d", k), 32'(inst_bus.addr_ok), 32'(!exp_d[k]));
      @(negedge clk);
      mem_bus.data_ok = 1;
      #4;
      chk($sformatf("t3_ddok%0d", k), 32'(data_bus.data_ok), 32'(exp_d[k]));
      chk($sformatf("t3_idok%0d", k), 32'(inst_bus.data_ok), 32'(!exp_d[k]));
      @(negedge clk);
      mem_bus.data_ok = 0;
    end

    // 4: slave stalls address; inst arriving later cannot steal the locked grant.
    do_reset();
    data_bus.req = 1; data_bus.addr = 32'h8000_5000; inst_bus.addr = 32'hBFC0_0300;
    #4;
    chk("t4_maddr0", mem_bus.addr, 32'h8000_5000);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      inst_bus.req = 1;
      #4;
      chk($sformatf("t4_maddr%0d", c), mem_bus.addr, 32'h8000_5000);
      chk($sformatf("t4_iaok%0d", c), 32'(inst_bus.addr_ok), 0);
    end
    @(negedge clk);
    mem_bus.addr_ok = 1;
    #4;
    chk("t4_daok", 32'(data_bus.addr_ok), 1);
    chk("t4_iaok3", 32'(inst_bus.addr_ok), 0);
    @(negedge clk);
    data_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
    #4;
    chk("t4_ddok", 32'(data_bus.data_ok), 1);
    @(negedge clk);
    mem_bus.data_ok = 0; mem_bus.addr_ok = 1;
    #4;
    chk("t4_iaok_after", 32'(inst_bus.addr_ok), 1);

    // 5: reset mid-transaction drops it.
    do_reset();
    data_bus.req = 1; data_bus.addr = 32'h8000_6000; mem_bus.addr_ok = 1;
    #4;
    chk("t5_daok", 32'(data_bus.addr_ok), 1);
    @(negedge clk);
    data_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.rdata = 32'hDEAD_BEEF;
    resetn = 1'b0;
    #4;
    chk("t5_rst_mreq", 32'(mem_bus.req), 0);
    chk("t5_rst_drdata", data_bus.rdata, 0);
    chk("t5_rst_ddok", 32'(data_bus.data_ok), 0);
    @(negedge clk);
    resetn = 1'b1; mem_bus.data_ok = 1;
    #4;
    chk("t5_ddok_dropped", 32'(data_bus.data_ok), 0);
    chk("t5_idok_dropped", 32'(inst_bus.data_ok), 0);
    @(negedge clk);
    mem_bus.data_ok = 0; inst_bus.req = 1; inst_bus.addr = 32'hBFC0_0400; mem_bus.addr_ok = 1;
    #4;
    chk("t5_iaok_idle", 32'(inst_bus.addr_ok), 1);

    // 6: stray data_ok while idle.
    do_reset();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h1111_2222;
    #4;
    chk("t6_idok", 32'(inst_bus.data_ok), 0);
    chk("t6_ddok", 32'(data_bus.data_ok), 0);
    @(negedge clk);
    mem_bus.data_ok = 0; data_bus.req = 1; data_bus.addr = 32'h8000_7000; mem_bus.addr_ok = 1;
    #4;
    chk("t6_daok_idle", 32'(data_bus.addr_ok), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
